// File: rtl/div_sched.sv
// Shared restoring shift-subtract divider serving two requesters.
// Round-robin grant in IDLE, one quotient bit per CALC cycle, result held in DONE.
module div_sched #(
    parameter int Nbits = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [Nbits-1:0] req0_dividend,
    input  logic [Nbits-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [Nbits-1:0] req1_dividend,
    input  logic [Nbits-1:0] req1_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [Nbits-1:0] rsp_quotient,
    output logic [Nbits-1:0] rsp_remainder,
    output logic             rsp_div_zero,
    output logic             busy
);

    localparam int CntW = (Nbits > 1) ? $clog2(Nbits) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic             last_grant;
    logic             grant_valid;
    logic             grant_id;
    logic [Nbits-1:0] op_dividend;
    logic [Nbits-1:0] op_divisor;
    logic [Nbits-1:0] rem, quo, dsr;
    logic [CntW-1:0]  cnt;
    logic             cur_id;
    logic [Nbits:0]   trial;
    logic             fits;
    logic [Nbits-1:0] rem_next, quo_next;
    logic             last_iter;

    // Arbitration: a lone requester wins; contention goes to the one not served last.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready  = grant_valid && !grant_id;
    assign req1_ready  = grant_valid && grant_id;
    assign op_dividend = grant_id ? req1_dividend : req0_dividend;
    assign op_divisor  = grant_id ? req1_divisor  : req0_divisor;

    // Compare/subtract one bit wider than the operands.
    always_comb begin
        trial     = {rem, quo[Nbits-1]};
        fits      = trial >= {1'b0, dsr};
        rem_next  = fits ? Nbits'(trial - {1'b0, dsr}) : trial[Nbits-1:0];
        quo_next  = {quo[Nbits-2:0], fits};
        last_iter = cnt == CntW'(Nbits - 1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_valid) state_next = (op_divisor == '0) ? DONE : CALC;
            CALC: if (last_iter) state_next = DONE;
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = state == DONE;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant    <= 1'b1;
            rem           <= '0;
            quo           <= '0;
            dsr           <= '0;
            cnt           <= '0;
            cur_id        <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_div_zero  <= 1'b0;
        end else begin
            if (state == IDLE && grant_valid) begin
                last_grant <= grant_id;
                cur_id     <= grant_id;
                dsr        <= op_divisor;
                rem        <= '0;
                quo        <= op_dividend;
                cnt        <= '0;
                if (op_divisor == '0) begin
                    rsp_id        <= grant_id;
                    rsp_quotient  <= '1;
                    rsp_remainder <= op_dividend;
                    rsp_div_zero  <= 1'b1;
                end
            end else if (state == CALC) begin
                rem <= rem_next;
                quo <= quo_next;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    rsp_id        <= cur_id;
                    rsp_quotient  <= quo_next;
                    rsp_remainder <= rem_next;
                    rsp_div_zero  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Directed self-checking bench for div_sched (Nbits=5).
module tb_div_sched;

    localparam int Nbits = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [Nbits-1:0] req0_dividend = '0;
    logic [Nbits-1:0] req0_divisor = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [Nbits-1:0] req1_dividend = '0;
    logic [Nbits-1:0] req1_divisor = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_id;
    logic [Nbits-1:0] rsp_quotient;
    logic [Nbits-1:0] rsp_remainder;
    logic             rsp_div_zero;
    logic             busy;

    int checks = 0;
    int failures = 0;

    div_sched #(.Nbits(Nbits)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_zero(rsp_div_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for its transfer, then for rsp_valid.
    // lat counts cycles from the transfer edge until rsp_valid is seen.
    task automatic run_op(input logic id, input logic [Nbits-1:0] a,
                          input logic [Nbits-1:0] b, output int lat);
        int n;
        if (!id) begin
            req0_valid = 1'b1; req0_dividend = a; req0_divisor = b;
        end else begin
            req1_valid = 1'b1; req1_dividend = a; req1_divisor = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            tick;
            n++;
        end
        tick;
        if (!id) req0_valid = 1'b0;
        else     req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1; req0_dividend = 5'd9; req0_divisor = 5'd2;
        req1_valid = 1'b1; req1_dividend = 5'd8; req1_divisor = 5'd3;
        tick;
        tick;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL reset_req0_ready got %b exp 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL reset_req1_ready got %b exp 0", req1_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
        checks++; if (rsp_quotient !== 5'd0) begin failures++; $display("FAIL reset_quotient got %0d exp 0", rsp_quotient); end
        checks++; if (rsp_remainder !== 5'd0) begin failures++; $display("FAIL reset_remainder got %0d exp 0", rsp_remainder); end
        checks++; if (rsp_div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got %b exp 0", rsp_div_zero); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int lat;
        rsp_ready = 1'b1;
        run_op(1'b0, 5'd23, 5'd4, lat);
        checks++; if (lat != 6) begin failures++; $display("FAIL basic_latency got %0d exp 6", lat); end
        checks++; if (rsp_quotient !== 5'd5) begin failures++; $display("FAIL basic_quotient got %0d exp 5", rsp_quotient); end
        checks++; if (rsp_remainder !== 5'd3) begin failures++; $display("FAIL basic_remainder got %0d exp 3", rsp_remainder); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL basic_id got %b exp 0", rsp_id); end
        checks++; if (rsp_div_zero !== 1'b0) begin failures++; $display("FAIL basic_div_zero got %b exp 0", rsp_div_zero); end
        tick;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_req1_pair;
        int lat;
        run_op(1'b1, 5'd31, 5'd1, lat);
        checks++; if (lat != 6) begin failures++; $display("FAIL r1a_latency got %0d exp 6", lat); end
        checks++; if (rsp_quotient !== 5'd31 || rsp_remainder !== 5'd0) begin failures++; $display("FAIL r1a_result got q=%0d r=%0d exp q=31 r=0", rsp_quotient, rsp_remainder); end
        checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL r1a_id got %b exp 1", rsp_id); end
        tick;
        run_op(1'b1, 5'd3, 5'd9, lat);
        checks++; if (rsp_quotient !== 5'd0 || rsp_remainder !== 5'd3) begin failures++; $display("FAIL r1b_result got q=%0d r=%0d exp q=0 r=3", rsp_quotient, rsp_remainder); end
        checks++; if (rsp_id !== 1'b1) begin failures++; $display("FAIL r1b_id got %b exp 1", rsp_id); end
        tick;
        run_op(1'b0, 5'd31, 5'd31, lat);
        checks++; if (rsp_quotient !== 5'd1 || rsp_remainder !== 5'd0) begin failures++; $display("FAIL max_result got q=%0d r=%0d exp q=1 r=0", rsp_quotient, rsp_remainder); end
        tick;
    endtask

    task automatic test_div_zero;
        int lat;
        run_op(1'b0, 5'd7, 5'd0, lat);
        checks++; if (lat != 1) begin failures++; $display("FAIL dz_latency got %0d exp 1", lat); end
        checks++; if (rsp_quotient !== 5'd31 || rsp_remainder !== 5'd7) begin failures++; $display("FAIL dz_result got q=%0d r=%0d exp q=31 r=7", rsp_quotient, rsp_remainder); end
        checks++; if (rsp_div_zero !== 1'b1 || rsp_id !== 1'b0) begin failures++; $display("FAIL dz_flags got dz=%b id=%b exp 1 0", rsp_div_zero, rsp_id); end
        tick;
    endtask

    task automatic test_alternate;
        int n;
        int lat;
        logic exp_id;
        logic [1:0] exp_grant;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_dividend = 5'd20; req0_divisor = 5'd3;
        req1_valid = 1'b1; req1_dividend = 5'd29; req1_divisor = 5'd5;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            exp_grant = exp_id ? 2'b10 : 2'b01;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 20) begin
                tick;
                n++;
            end
            checks++; if ({req1_ready, req0_ready} !== exp_grant) begin failures++; $display("FAIL alt_grant%0d got %b exp %b", k, {req1_ready, req0_ready}, exp_grant); end
            tick;
            lat = 1;
            while (!rsp_valid && lat < 40) begin
                tick;
                lat++;
            end
            checks++; if (rsp_id !== exp_id) begin failures++; $display("FAIL alt_id%0d got %b exp %b", k, rsp_id, exp_id); end
            checks++; if (rsp_quotient !== (exp_id ? 5'd5 : 5'd6) || rsp_remainder !== (exp_id ? 5'd4 : 5'd2)) begin
                failures++; $display("FAIL alt_result%0d got q=%0d r=%0d", k, rsp_quotient, rsp_remainder);
            end
            tick;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
    endtask

    task automatic test_stall;
        int lat;
        rsp_ready = 1'b0;
        run_op(1'b0, 5'd26, 5'd7, lat);
        req1_valid = 1'b1; req1_dividend = 5'd9; req1_divisor = 5'd2;
        #1;
        checks++; if (lat != 6) begin failures++; $display("FAIL stall_latency got %0d exp 6", lat); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_quotient !== 5'd3 || rsp_remainder !== 5'd5 || rsp_id !== 1'b0 ||
                rsp_div_zero !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%b q=%0d r=%0d id=%b rdy=%b%b exp v=1 q=3 r=5 id=0 rdy=00",
                         i, rsp_valid, rsp_quotient, rsp_remainder, rsp_id, req1_ready, req0_ready);
            end
            tick;
        end
        rsp_ready = 1'b1;
        tick;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stall_release got valid=%b busy=%b exp 0 0", rsp_valid, busy); end
        req1_valid = 1'b0;
        tick;
    endtask

    task automatic test_abort;
        int n;
        logic seen;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_dividend = 5'd22; req0_divisor = 5'd3;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin
            tick;
            n++;
        end
        tick;
        req0_valid = 1'b0;
        tick;
        tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_calc_busy got %b exp 1", busy); end
        rst = 1'b1;
        tick;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL abort_state got busy=%b valid=%b exp 0 0", busy, rsp_valid); end
        checks++; if (rsp_quotient !== 5'd0 || rsp_remainder !== 5'd0) begin failures++; $display("FAIL abort_rsp_regs got q=%0d r=%0d exp 0 0", rsp_quotient, rsp_remainder); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_response got %b exp 0", seen); end
        req0_valid = 1'b1; req0_dividend = 5'd20; req0_divisor = 5'd3;
        req1_valid = 1'b1; req1_dividend = 5'd29; req1_divisor = 5'd5;
        #1;
        checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL abort_regrant got %b exp 01", {req1_ready, req0_ready}); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_req1_pair;
        test_div_zero;
        test_alternate;
        test_stall;
        test_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Shared multi-cycle divider with a built-in scheduler. Two requesters share one Nbits restoring shift-subtract divide engine through valid/ready handshakes.
- A round-robin arbiter grants the engine. An FSM runs one quotient bit per cycle and holds each result until the consumer accepts it.
- Sits between the ALU-side requesters and the result bus. It replaces the unrolled combinational divider where timing or area matters.

Parameters:
- Nbits, 5, operand/result width (unsigned); iteration count = Nbits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req0_dividend  input  Nbits  requester 0 dividend.
- req0_divisor  input  Nbits  requester 0 divisor.
- req1_valid / req1_ready / req1_dividend / req1_divisor  same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester index the result belongs to.
- rsp_quotient  output  Nbits  quotient.
- rsp_remainder  output  Nbits  remainder.
- rsp_div_zero  output  1  divisor was zero.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset state: IDLE, last_grant=1 (req0 wins first). rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_div_zero and busy all 0. Both req*_ready are 0 while rst is high.
- States: IDLE, CALC, DONE.
- IDLE, arbitration (combinational):
  - Only one valid: grant it.
  - Both valid: grant the index != last_grant.
  - reqN_ready=1 only for the granted index, only in IDLE.
  - At most one ready is high per cycle. Ready does not depend on rsp_ready.
- IDLE, transfer edge (valid & ready):
  - Latch dividend, divisor and id; last_grant <= id.
  - divisor==0 -> DONE with quotient=all ones, remainder=dividend, div_zero=1.
  - Else -> CALC with rem=0, quo=dividend, cnt=0.
- CALC, each cycle (restoring division):
  - Form t = {rem, quo MSB} (Nbits+1 bits); quo <<= 1.
  - If t >= divisor: rem = t - divisor, quo LSB = 1. Else rem = t[Nbits-1:0], quo LSB = 0.
  - cnt++. After the Nbits-th iteration -> DONE.
  - Width: the compare/subtract is Nbits+1 bits wide, so the result must be correct for all operands, including dividend=2^Nbits-1.
- Latency, measured from the transfer edge:
  - rsp_valid is high Nbits+1 cycles later (6 for Nbits=5).
  - For div-by-zero, rsp_valid is high the next cycle.
- DONE:
  - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
  - On that edge -> IDLE and rsp_valid=0.
  - No new request is accepted in the same cycle, so throughput is one op per Nbits+2 cycles minimum.
- Result data: rsp_quotient, rsp_remainder, rsp_div_zero and rsp_id are registered. Their values outside rsp_valid are don't-care but must hold the last result.
- Requester rules: once reqN_valid is high it is held high with stable operands until reqN_ready. The block does not check this.
- busy=1 in CALC and DONE.
- Reset mid-operation (CALC or DONE): the in-flight operation is discarded, no response is produced, and all reset values are restored.
- rsp_ready high while not in DONE: ignored.

Test Plan:
- Nbits=5, req0 23/4, rsp_ready=1 -> rsp_valid 6 cycles after transfer; q=5, r=3, id=0, div_zero=0.
- req1 31/1, then req1 3/9 -> q=31,r=0; then q=0,r=3; id=1 both.
- req0 7/0 -> rsp_valid next cycle; q=31, r=7, div_zero=1, id=0.
- req0 and req1 held valid simultaneously from reset -> grants alternate 0,1,0,1; never both ready in one cycle; each result carries the matching id and quotient.
- rsp_ready low for 10 cycles in DONE -> rsp_valid stays 1 with all rsp_* stable; no reqN_ready during the stall; on release, IDLE next cycle.
- rst pulsed at CALC cnt=2 -> next cycle IDLE, busy=0, rsp_valid=0; no response for the aborted op; next simultaneous request is granted to req0.
